// File: rtl/xorshift_source.sv
// Per-CPU xorshift64 word source: presents a fixed number of pseudo-random words
// on a valid/ready handshake, optionally idling between words, then raises a sticky done flag.
module xorshift_source #(
    parameter int unsigned CPU_INDEX      = 0,
    parameter int unsigned TRANSACTION_NB = 16,
    parameter int unsigned GAP_CYCLES     = 3,
    parameter logic [63:0] SEED           = 64'h9E3779B97F4A7C15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        data_rdy,
    output logic        data_vld,
    output logic [63:0] data,
    output logic        transactions_done
);

    localparam logic [63:0] EFF_SEED = SEED ^ 64'(CPU_INDEX);
    localparam int CW = $clog2(TRANSACTION_NB + 1);
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [CW:0] NB_W = (CW + 1)'(TRANSACTION_NB);
    localparam logic [GW-1:0] GAP_LOAD = GW'(GAP_CYCLES - 1);

    generate
        if (EFF_SEED == 64'd0) begin : g_bad_seed
            $error("xorshift_source: effective seed is zero, generator would stick at 0");
        end
    endgenerate

    typedef enum logic [1:0] {SEND, GAP, DONE} fsm_t;

    function automatic logic [63:0] step(input logic [63:0] x);
        logic [63:0] y;
        y = x ^ (x << 13);
        y = y ^ (y >> 7);
        y = y ^ (y << 17);
        return y;
    endfunction

    fsm_t          fsm_q, fsm_d;
    logic          run_q;
    logic [63:0]   state_q;
    logic [63:0]   data_q;
    logic [CW-1:0] count_q;
    logic [GW-1:0] gap_cnt_q;
    logic          accept;
    logic          last;

    // run_q is the synchronised release: outputs stay quiet until the first posedge out of reset.
    assign data_vld          = run_q && (fsm_q == SEND);
    assign transactions_done = (fsm_q == DONE);
    assign data              = data_vld ? state_q : data_q;
    assign accept            = data_vld && data_rdy;
    assign last              = ({1'b0, count_q} + (CW + 1)'(1)) == NB_W;

    always_comb begin
        fsm_d = fsm_q;
        case (fsm_q)
            SEND: if (accept) begin
                if (last)                 fsm_d = DONE;
                else if (GAP_CYCLES == 0) fsm_d = SEND;
                else                      fsm_d = GAP;
            end
            GAP:  if (gap_cnt_q == '0) fsm_d = SEND;
            DONE: fsm_d = DONE;
            default: fsm_d = SEND;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q     <= 1'b0;
            fsm_q     <= SEND;
            state_q   <= EFF_SEED;
            data_q    <= '0;
            count_q   <= '0;
            gap_cnt_q <= '0;
        end else begin
            run_q <= 1'b1;
            fsm_q <= fsm_d;
            if (accept) begin
                state_q <= step(state_q);
                data_q  <= state_q;
                count_q <= count_q + CW'(1);
                if (!last && GAP_CYCLES != 0) gap_cnt_q <= GAP_LOAD;
            end else if (fsm_q == GAP && gap_cnt_q != '0) begin
                gap_cnt_q <= gap_cnt_q - GW'(1);
            end
        end
    end

endmodule

// File: tb/tb_xorshift_source.sv
// Scoreboard bench for xorshift_source: one gapped NB=4 instance and one back-to-back NB=16 instance.
module tb_xorshift_source;

    localparam logic [63:0] SEED0 = 64'h9E3779B97F4A7C15;
    localparam logic [63:0] SEED5 = 64'h9E3779B97F4A7C10;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a, rdy_a, vld_a, done_a;
    logic rst_b, rdy_b, vld_b, done_b;
    logic [63:0] data_a, data_b;

    xorshift_source #(.CPU_INDEX(0), .TRANSACTION_NB(4), .GAP_CYCLES(3)) dut_a (
        .clk(clk), .rst_n(rst_a), .data_rdy(rdy_a),
        .data_vld(vld_a), .data(data_a), .transactions_done(done_a));

    xorshift_source #(.CPU_INDEX(5), .TRANSACTION_NB(16), .GAP_CYCLES(0)) dut_b (
        .clk(clk), .rst_n(rst_b), .data_rdy(rdy_b),
        .data_vld(vld_b), .data(data_b), .transactions_done(done_b));

    int tests = 0;
    int fails = 0;
    logic [63:0] q_a[$];
    logic [63:0] q_b[$];
    logic [63:0] alt_b[$];
    logic [63:0] ea, eb, ab;
    logic [63:0] last_a;

    function automatic logic [63:0] model_step(input logic [63:0] x);
        logic [63:0] t;
        t = x;
        t = t ^ {t[50:0], 13'b0};
        t = t ^ {7'b0, t[63:7]};
        t = t ^ {t[46:0], 17'b0};
        return t;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic push_a();
        logic [63:0] x;
        x = SEED0;
        for (int k = 0; k < 4; k++) begin
            q_a.push_back(x);
            last_a = x;
            x = model_step(x);
        end
    endtask

    // Monitors: every cycle that will be accepted at the next posedge pops one expected word.
    always @(negedge clk) begin
        if (rst_a && vld_a && rdy_a) begin
            if (q_a.size() == 0) chk("a_unexpected_word", 64'd1, 64'd0);
            else begin
                ea = q_a.pop_front();
                chk("a_word", data_a, ea);
            end
        end
    end

    always @(negedge clk) begin
        if (rst_b && vld_b && rdy_b) begin
            if (q_b.size() == 0) chk("b_unexpected_word", 64'd1, 64'd0);
            else begin
                eb = q_b.pop_front();
                ab = alt_b.pop_front();
                chk("b_word", data_b, eb);
                tests++;
                if (data_b === ab) begin
                    fails++;
                    $display("FAIL b_differs_from_cpu0: got %h, must differ from %h", data_b, ab);
                end
            end
        end
    end

    initial begin
        logic [63:0] x, y;
        rst_a = 1'b0; rst_b = 1'b0; rdy_a = 1'b1; rdy_b = 1'b1;
        push_a();
        x = SEED5; y = SEED0;
        for (int k = 0; k < 16; k++) begin
            q_b.push_back(x); alt_b.push_back(y);
            x = model_step(x); y = model_step(y);
        end

        repeat (2) @(negedge clk);
        chk("reset_vld_a", 64'(vld_a), 64'd0);
        chk("reset_done_a", 64'(done_a), 64'd0);
        chk("reset_data_a", data_a, 64'd0);
        chk("reset_vld_b", 64'(vld_b), 64'd0);
        chk("reset_done_b", 64'(done_b), 64'd0);
        chk("reset_data_b", data_b, 64'd0);
        #2; rst_a = 1'b1; rst_b = 1'b1;

        // Gapped stream: vld at cycles 1,5,9,13; done from 14. Back-to-back: vld 1..16, done at 17.
        for (int i = 1; i <= 17; i++) begin
            @(negedge clk);
            if (i == 1) begin
                chk("a_word0_const", data_a, 64'h9E3779B97F4A7C15);
                chk("b_word0_const", data_b, 64'h9E3779B97F4A7C10);
            end
            if (i <= 16) begin
                chk("a_vld_pattern", 64'(vld_a), 64'((i % 4 == 1) && (i <= 13)));
                chk("a_done_pattern", 64'(done_a), 64'(i >= 14));
            end
            chk("b_vld_pattern", 64'(vld_b), 64'(i <= 16));
            chk("b_done_pattern", 64'(done_b), 64'(i >= 17));
        end
        chk("a_queue_drained", 64'(q_a.size()), 64'd0);
        chk("b_queue_drained", 64'(q_b.size()), 64'd0);

        // After done, rdy is ignored and outputs hold.
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1 rdy_a = 1'($urandom);
            @(negedge clk);
            chk("post_done_vld", 64'(vld_a), 64'd0);
            chk("post_done_done", 64'(done_a), 64'd1);
            chk("post_done_data", data_a, last_a);
        end

        // Restart, then async reset in the gap after the second accept.
        rst_a = 1'b0; rdy_a = 1'b1;
        @(negedge clk); #2 rst_a = 1'b1;
        push_a();
        repeat (6) @(negedge clk);
        chk("mid_q_remaining", 64'(q_a.size()), 64'd2);
        chk("mid_data_before_rst", data_a, model_step(SEED0));
        #2 rst_a = 1'b0;
        #1;
        chk("async_rst_vld", 64'(vld_a), 64'd0);
        chk("async_rst_done", 64'(done_a), 64'd0);
        chk("async_rst_data", data_a, 64'd0);
        q_a.delete();
        @(negedge clk); #2 rst_a = 1'b1;
        push_a();
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            chk("rst_vld_pattern", 64'(vld_a), 64'((i % 4 == 1) && (i <= 13)));
            chk("rst_done_pattern", 64'(done_a), 64'(i >= 14));
        end
        chk("rst_queue_drained", 64'(q_a.size()), 64'd0);

        // Backpressure: rdy low for 10 cycles while vld is up.
        rst_a = 1'b0; rdy_a = 1'b0;
        @(negedge clk); #2 rst_a = 1'b1;
        push_a();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("stall_vld", 64'(vld_a), 64'd1);
            chk("stall_data", data_a, SEED0);
        end
        @(posedge clk); #1 rdy_a = 1'b1;
        @(negedge clk);
        chk("stall_release_vld", 64'(vld_a), 64'd1);
        @(negedge clk);
        chk("accept_first_rdy", 64'(vld_a), 64'd0);
        repeat (20) @(negedge clk);
        chk("stall_done", 64'(done_a), 64'd1);
        chk("stall_queue_drained", 64'(q_a.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
